cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: MESI set-associative cache controller with true-LRU replacement.
// Define CACHE_STATS_EN to build the hit/miss statistics counters.
module cache_ctrl #(
  parameter  int SETS   = 16384,
  parameter  int WAYS   = 8,
  parameter  int TAG_W  = 12,
  localparam int SET_W  = $clog2(SETS),
  localparam int LRU_W  = $clog2(WAYS),
  localparam int LINE_W = TAG_W + 2 + LRU_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_n,
  input  logic [31:0]              cmd_addr,
  output logic                     rd_en,
  output logic [SET_W-1:0]         rd_set,
  input  logic [WAYS*LINE_W-1:0]   rd_lines,
  output logic                     wr_en,
  output logic [SET_W-1:0]         wr_set,
  output logic [WAYS*LINE_W-1:0]   wr_lines,
  output logic                     hit,
  output logic                     miss,
  output logic [2:0]               bus_op,
  output logic                     wb_valid,
  output logic [31:0]              wb_addr,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_CLEAR  = 2'd3;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_E = 2'd2;
  localparam logic [1:0] ST_M = 2'd3;

  localparam logic [2:0] BUS_NONE  = 3'd0;
  localparam logic [2:0] BUS_READ  = 3'd1;
  localparam logic [2:0] BUS_WRITE = 3'd2;
  localparam logic [2:0] BUS_INV   = 3'd3;
  localparam logic [2:0] BUS_RFO   = 3'd4;

  localparam logic [LRU_W-1:0] MRU      = LRU_W'(WAYS - 1);
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [SET_W-1:0] clr_q, clr_d;

  logic unused_offset;
  assign unused_offset = ^cmd_addr[5:0];

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    tag_d   = tag_q;
    set_d   = set_q;
    clr_d   = clr_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d = cmd_n;
          tag_d = cmd_addr[31 -: TAG_W];
          set_d = cmd_addr[6 +: SET_W];
          clr_d = '0;
          if (cmd_n <= 4'd4 || cmd_n == 4'd9)
            state_d = S_LOOKUP;
          else if (cmd_n == 4'd8)
            state_d = S_CLEAR;
        end
      end
      S_LOOKUP: state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      S_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == LAST_SET)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      tag_q   <= '0;
      set_q   <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      tag_q   <= tag_d;
      set_q   <= set_d;
      clr_q   <= clr_d;
    end
  end

  logic [TAG_W-1:0] o_tag [WAYS];
  logic [1:0]       o_st  [WAYS];
  logic [LRU_W-1:0] o_lru [WAYS];

  always_comb begin
    for (int w = 0; w < WAYS; w++)
      {o_tag[w], o_st[w], o_lru[w]} = rd_lines[w*LINE_W +: LINE_W];
  end

  logic             match, has_inv;
  logic [LRU_W-1:0] hit_w, vic_w;

  // Descending scans so the lowest-index candidate wins.
  always_comb begin
    match   = 1'b0;
    has_inv = 1'b0;
    hit_w   = '0;
    vic_w   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (o_st[w] != ST_I && o_tag[w] == tag_q) begin
        match = 1'b1;
        hit_w = LRU_W'(w);
      end
      if (o_st[w] == ST_I) begin
        has_inv = 1'b1;
        vic_w   = LRU_W'(w);
      end
    end
    if (!has_inv) begin
      for (int w = WAYS - 1; w >= 0; w--)
        if (o_lru[w] == '0)
          vic_w = LRU_W'(w);
    end
  end

  logic is_rd, is_wr, is_sinv, is_srd, is_lkp;
  assign is_rd   = (cmd_q == 4'd0) || (cmd_q == 4'd2);
  assign is_wr   = (cmd_q == 4'd1);
  assign is_sinv = (cmd_q == 4'd3);
  assign is_srd  = (cmd_q == 4'd4);
  assign is_lkp  = is_rd || is_wr;

  logic [TAG_W-1:0] n_tag [WAYS];
  logic [1:0]       n_st  [WAYS];
  logic [LRU_W-1:0] n_lru [WAYS];
  logic [LRU_W-1:0] acc_w;
  logic             acc, wb_c;
  logic [2:0]       bus_c;

  always_comb begin
    n_tag = o_tag;
    n_st  = o_st;
    n_lru = o_lru;
    acc   = 1'b0;
    acc_w = match ? hit_w : vic_w;
    bus_c = BUS_NONE;
    wb_c  = 1'b0;
    if (state_q == S_UPDATE) begin
      unique case (1'b1)
        is_rd: begin
          acc = 1'b1;
          if (!match) begin
            n_tag[vic_w] = tag_q;
            n_st[vic_w]  = ST_E;
            bus_c        = BUS_READ;
            wb_c         = (o_st[vic_w] == ST_M);
          end
        end
        is_wr: begin
          acc         = 1'b1;
          n_st[acc_w] = ST_M;
          if (match) begin
            if (o_st[hit_w] == ST_S)
              bus_c = BUS_INV;
          end else begin
            n_tag[vic_w] = tag_q;
            bus_c        = BUS_RFO;
            wb_c         = (o_st[vic_w] == ST_M);
          end
        end
        is_sinv: begin
          if (match && o_st[hit_w] == ST_S)
            n_st[hit_w] = ST_I;
        end
        is_srd: begin
          if (match) begin
            n_st[hit_w] = ST_S;
            if (o_st[hit_w] == ST_M) begin
              bus_c = BUS_WRITE;
              wb_c  = 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (acc) begin
        for (int w = 0; w < WAYS; w++)
          if (o_lru[w] > o_lru[acc_w])
            n_lru[w] = o_lru[w] - 1'b1;
        n_lru[acc_w] = MRU;
      end
    end
  end

  logic [WAYS*LINE_W-1:0] upd_lines, clr_lines;

  always_comb begin
    upd_lines = '0;
    clr_lines = '0;
    for (int w = 0; w < WAYS; w++) begin
      upd_lines[w*LINE_W +: LINE_W] = {n_tag[w], n_st[w], n_lru[w]};
      clr_lines[w*LINE_W +: LINE_W] = {{TAG_W{1'b0}}, ST_I, LRU_W'(w)};
    end
  end

  logic [TAG_W-1:0] wb_tag;
  assign wb_tag = is_srd ? tag_q : o_tag[vic_w];

  assign cmd_ready = (state_q == S_IDLE);
  assign rd_en     = (state_q == S_LOOKUP);
  assign rd_set    = set_q;
  assign wr_set    = (state_q == S_CLEAR) ? clr_q : set_q;
  assign wr_lines  = (state_q == S_CLEAR) ? clr_lines : upd_lines;
  assign wr_en     = (state_q == S_CLEAR) ||
                     (state_q == S_UPDATE && cmd_q != 4'd9 &&
                      upd_lines != rd_lines);
  assign hit       = (state_q == S_UPDATE) && is_lkp && match;
  assign miss      = (state_q == S_UPDATE) && is_lkp && !match;
  assign bus_op    = bus_c;
  assign wb_valid  = wb_c;
  assign wb_addr   = wb_c ? {wb_tag, set_q, 6'b0} : 32'd0;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        clr_start;
  assign clr_start = cmd_ready && cmd_valid && (cmd_n == 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (clr_start) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && state_q == S_UPDATE && cmd_q == 4'd9)
      $display("cache_ctrl set %0h lines %h", set_q, rd_lines);
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed self-checking bench for cache_ctrl.
// Storage is a behavioural set array answering rd_en one cycle later.
module tb_cache_ctrl;
  localparam int SETS   = 16384;
  localparam int WAYS   = 8;
  localparam int TAG_W  = 12;
  localparam int SET_W  = 14;
  localparam int LRU_W  = 3;
  localparam int LINE_W = 17;
  localparam int VW     = WAYS * LINE_W;

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [1:0] MI = 2'd0;
  localparam logic [1:0] MS = 2'd1;
  localparam logic [1:0] ME = 2'd2;
  localparam logic [1:0] MM = 2'd3;

  logic             clk, rst_n;
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_n;
  logic [31:0]      cmd_addr;
  logic             rd_en, wr_en;
  logic [SET_W-1:0] rd_set, wr_set;
  logic [VW-1:0]    rd_lines, wr_lines;
  logic             hit, miss, wb_valid;
  logic [2:0]       bus_op;
  logic [31:0]      wb_addr, hit_count, miss_count;

  cache_ctrl #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_n(cmd_n), .cmd_addr(cmd_addr),
    .rd_en(rd_en), .rd_set(rd_set), .rd_lines(rd_lines),
    .wr_en(wr_en), .wr_set(wr_set), .wr_lines(wr_lines),
    .hit(hit), .miss(miss), .bus_op(bus_op),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [VW-1:0] mem [SETS];
  always @(posedge clk) begin
    if (rd_en) rd_lines <= mem[rd_set];
    if (wr_en) mem[wr_set] <= wr_lines;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got,
                     input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] ln(input logic [TAG_W-1:0] t,
                                           input logic [1:0] s,
                                           input int l);
    return {t, s, LRU_W'(l)};
  endfunction

  function automatic logic [VW-1:0] clr_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int w = 0; w < WAYS; w++)
      v[w*LINE_W +: LINE_W] = ln('0, MI, w);
    return v;
  endfunction

  function automatic logic [31:0] adr5(input logic [TAG_W-1:0] t);
    return {t, 14'h0005, 6'h00};
  endfunction

  logic             o_rdy, o_rd, o_hit, o_miss, o_wb, o_wr;
  logic [SET_W-1:0] o_rdset, o_wrset;
  logic [2:0]       o_bus;
  logic [31:0]      o_wba;
  logic [VW-1:0]    o_wrl;

  task automatic do_cmd(input logic [3:0] n, input logic [31:0] a);
    @(negedge clk);
    o_rdy     = cmd_ready;
    cmd_valid = 1'b1;
    cmd_n     = n;
    cmd_addr  = a;
    @(negedge clk);
    cmd_valid = 1'b0;
    o_rd      = rd_en;
    o_rdset   = rd_set;
    @(negedge clk);
    o_hit   = hit;
    o_miss  = miss;
    o_bus   = bus_op;
    o_wb    = wb_valid;
    o_wba   = wb_addr;
    o_wr    = wr_en;
    o_wrl   = wr_lines;
    o_wrset = wr_set;
    @(negedge clk);
  endtask

  task automatic do_clear(output int cnt, output bit done);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_n     = 4'd8;
    cmd_addr  = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < SETS + 8 && !done; i++) begin
      if (cmd_ready) done = 1'b1;
      else begin
        if (wr_en) cnt++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [31:0]   a;
    logic [VW-1:0] e;
    int            cnt, nwr, bad;
    bit            done, found;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_n = '0; cmd_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_pulses", {hit, miss, wb_valid, bus_op}, 0);
    chk("rst_sets", {rd_set, wr_set}, 0);
    chk("rst_counts", {hit_count, miss_count}, 0);
    rst_n = 1'b1;

    do_clear(cnt, done);
    chk("clr_done", done, 1);
    chk("clr_cycles", cnt, SETS);
    chk("clr_set0", mem[0], clr_vec());
    chk("clr_last", mem[SETS-1], clr_vec());

    a = 32'h1234_5678;
    do_cmd(4'd0, a);
    chk("r1_ready", o_rdy, 1);
    chk("r1_rd_en", o_rd, 1);
    chk("r1_rd_set", o_rdset, 14'h1159);
    chk("r1_hit_miss", {o_hit, o_miss}, 2'b01);
    chk("r1_bus", o_bus, 3'd1);
    chk("r1_wb", o_wb, 0);
    chk("r1_wr_en", o_wr, 1);
    chk("r1_wr_set", o_wrset, 14'h1159);
    e = clr_vec();
    e[0 +: LINE_W] = ln(12'h123, ME, 7);
    for (int w = 1; w < WAYS; w++)
      e[w*LINE_W +: LINE_W] = ln('0, MI, w - 1);
    chk("r1_lines", o_wrl, e);

    do_cmd(4'd0, a);
    chk("r2_hit_miss", {o_hit, o_miss}, 2'b10);
    chk("r2_bus", o_bus, 0);
    chk("r2_wr_en", o_wr, 0);
    chk("r2_hits", hit_count, STATS ? 32'd1 : 32'd0);
    chk("r2_misses", miss_count, STATS ? 32'd1 : 32'd0);

    do_cmd(4'd1, a);
    chk("w1_hit_miss", {o_hit, o_miss}, 2'b10);
    chk("w1_bus", o_bus, 0);
    chk("w1_wr_en", o_wr, 1);
    e[0 +: LINE_W] = ln(12'h123, MM, 7);
    chk("w1_lines", o_wrl, e);

    do_cmd(4'd4, a);
    chk("sr1_pulses", {o_hit, o_miss}, 2'b00);
    chk("sr1_bus", o_bus, 3'd2);
    chk("sr1_wb", o_wb, 1);
    chk("sr1_wb_addr", o_wba, 32'h1234_5640);
    e[0 +: LINE_W] = ln(12'h123, MS, 7);
    chk("sr1_lines", o_wrl, e);

    do_cmd(4'd1, a);
    chk("w2_bus", o_bus, 3'd3);
    e[0 +: LINE_W] = ln(12'h123, MM, 7);
    chk("w2_lines", o_wrl, e);

    do_cmd(4'd4, a);
    chk("sr2_bus", o_bus, 3'd2);
    do_cmd(4'd3, a);
    chk("si1_bus", o_bus, 0);
    chk("si1_wr_en", o_wr, 1);
    e[0 +: LINE_W] = ln(12'h123, MI, 7);
    chk("si1_lines", o_wrl, e);
    do_cmd(4'd3, a);
    chk("si2_wr_en", o_wr, 0);
    chk("phase1_hits", hit_count, STATS ? 32'd3 : 32'd0);
    chk("phase1_misses", miss_count, STATS ? 32'd1 : 32'd0);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_n = 4'd5; cmd_addr = a;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("disc_ready", cmd_ready, 1);
      chk("disc_activity", {rd_en, wr_en, bus_op}, 0);
    end
    cmd_valid = 1'b0;

    do_cmd(4'd9, a);
    chk("prt_rd_en", o_rd, 1);
    chk("prt_quiet", {o_wr, o_hit, o_miss, o_bus, o_wb}, 0);

    do_clear(cnt, done);
    chk("clr2_done", done, 1);
    chk("clr2_cycles", cnt, SETS);
    chk("clr2_counts", {hit_count, miss_count}, 0);

    for (int t = 1; t <= 9; t++) begin
      do_cmd(4'd0, adr5(TAG_W'(t)));
      chk("fill_miss", {o_hit, o_miss}, 2'b01);
    end
    chk("ev_bus", o_bus, 3'd1);
    chk("ev_wb", o_wb, 0);
    e = '0;
    e[0 +: LINE_W] = ln(12'h009, ME, 7);
    for (int w = 1; w < WAYS; w++)
      e[w*LINE_W +: LINE_W] = ln(TAG_W'(w + 1), ME, w - 1);
    chk("ev_lines", o_wrl, e);
    chk("ev_misses", miss_count, STATS ? 32'd9 : 32'd0);

    do_cmd(4'd0, adr5(12'h001));
    chk("re1_miss", {o_hit, o_miss}, 2'b01);
    chk("re1_way1", o_wrl[LINE_W +: LINE_W], ln(12'h001, ME, 7));
    do_cmd(4'd0, adr5(12'h009));
    chk("re9_hit", {o_hit, o_miss}, 2'b10);

    do_cmd(4'd1, adr5(12'h00A));
    chk("rfo_miss", {o_hit, o_miss}, 2'b01);
    chk("rfo_bus", o_bus, 3'd4);
    chk("rfo_way2", o_wrl[2*LINE_W +: LINE_W], ln(12'h00A, MM, 7));
    for (int t = 4; t <= 10; t++) begin
      do_cmd(4'd0, adr5(t == 10 ? 12'h009 : TAG_W'(t)));
      chk("age_hit", {o_hit, o_miss}, 2'b10);
    end
    do_cmd(4'd0, adr5(12'h001));
    chk("age_hit1", {o_hit, o_miss}, 2'b10);
    do_cmd(4'd0, adr5(12'h00B));
    chk("evm_miss", {o_hit, o_miss}, 2'b01);
    chk("evm_bus", o_bus, 3'd1);
    chk("evm_wb", o_wb, 1);
    chk("evm_wb_addr", o_wba, 32'h00A0_0140);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_n = 4'd8; cmd_addr = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (wr_en && wr_set == SET_W'(100)) found = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reach", found, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_wr", wr_en, 0);
    chk("abort_rst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    nwr = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_en) nwr++;
      if (!cmd_ready) bad++;
    end
    chk("abort_no_wr", nwr, 0);
    chk("abort_ready", bad, 0);
    chk("abort_counts", {hit_count, miss_count}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
